retry_inorder_source: RTL and testbench
=======================================

# retry_inorder_source

Issuing side of the in-order retry pair. Accepts operations from upstream, tags each with a unique rolling ID, and keeps a copy of its data in an ID-indexed replay buffer. It sends the operation into the protected (pipelined) datapath, whose far end judges results. When the far end flags elements for retry, it hands their IDs back over the retry interface; this block replays the stored data with fresh IDs ahead of any new upstream traffic, so results stay in order.

## Interface
- DataType, logic: operation payload type.
- IDSize, 1: ID width; replay buffer depth is 2**IDSize.
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous and active-high.
- data_i  in  DataType  upstream payload.
- valid_i  in  1  upstream valid.
- ready_o  out  1  upstream ready.
- data_o  out  DataType  payload into the datapath.
- id_o  out  IDSize  ID travelling alongside data_o with the same handshake.
- valid_o  out  1  datapath valid.
- ready_i  in  1  datapath ready.
- retry  modport start of retry_interface. Signals:
  - retry.valid  in  1  an element is being returned for replay.
  - retry.id  in  IDSize  ID of the returned element.
  - retry.ready  out  1  replay accepted.
  - retry.lock  in  1  far end is in retry mode; new upstream intake is forbidden.
  - retry.id_feedback  out  IDSize  ID of the most recently issued element.

## Operation
- State: id_q (next ID to issue), mem[2**IDSize] of DataType (no reset).
- Source select, combinational, each cycle:
  - Replay: retry.valid=1. Set data_o=mem[retry.id], valid_o=1, retry.ready=ready_i, ready_o=0.
  - New: retry.valid=0 and retry.lock=0. Set data_o=data_i, valid_o=valid_i, ready_o=ready_i, retry.ready=0.
  - Hold: retry.valid=0 and retry.lock=1. Set valid_o=0, ready_o=0, retry.ready=0.
- id_o = id_q in all modes.
- Issue event: valid_o & ready_i.
  - On an issue event, mem[id_q] <= data_o and id_q <= id_q+1, wrapping modulo 2**IDSize.
  - Replayed data is therefore re-stored under its new ID. A replay can itself fail and be replayed again.
- retry.id_feedback = id_q-1 modulo 2**IDSize, combinational. The far end latches it on failure as the last in-flight ID. It then returns every element up to and including that ID.
- Replay priority over new traffic is absolute; replays are issued in the order returned.
- Uniqueness: at most 2**IDSize elements may be in flight. Exceeding this is an integration error and is not detected.
- Same-cycle replay read and issue write: a replay of ID k while id_q=k reads old mem[k] before the write. This case cannot arise legally.

## Timing
- Zero-latency forwarding. data_o, valid_o, ready_o and retry.ready are combinational from the inputs and id_q.
- Combinational paths:
  - ready_i to ready_o and to retry.ready.
  - retry.valid and retry.lock to valid_o and ready_o.
- Reset, while rst_i=1 and on the first cycle after release:
  - id_q=0, so id_o=0 and retry.id_feedback=2**IDSize-1.
  - With valid_i=0 and retry.valid=0: valid_o=0, retry.ready=0; ready_o follows ready_i.
- Reset mid-operation: id_q returns to 0 on the next edge; buffered data is abandoned. The datapath and far end must be reset in the same cycle.
- Handshakes: valid_o never depends on ready_i. An offered element must stay stable until accepted, provided upstream and retry-side valids obey AXI-style stability.
- Lock rising while valid_i is held: upstream is stalled, not dropped; transfer resumes the cycle lock falls.

## Test plan
- IDSize=2, lock=0, retry idle, 4 transfers D0..D3 with ready_i=1 -> id_o 0,1,2,3, one per cycle. Then id_o wraps to 0; id_feedback reads 3 after the 4th transfer.
- Failure replay: issue A(0), B(1), C(2); far end asserts lock and returns IDs 1, 2 -> data_o B then C with id_o 3, 0. ready_o=0 throughout. New data_i D is issued as id 1 only after lock drops.
- Backpressure during replay: retry.valid=1 with id 1 and ready_i=0 for 3 cycles -> valid_o=1, retry.ready=0, id_q unchanged. On ready_i=1, one transfer happens and id_q advances by 1.
- Lock with no return yet: lock=1, retry.valid=0, valid_i=1 -> valid_o=0, ready_o=0 for every locked cycle; no ID consumed.
- Reset mid-stream: after 5 issues, pulse rst_i one cycle -> next cycle id_o=0 and id_feedback=2**IDSize-1. The first post-reset transfer carries id 0.
- Repeated failure: a replayed element (new ID 3) is returned again -> it is reissued with id_o=id_q, and its payload is bit-identical to the original data_i.

Source files
------------

// File: rtl/retry_inorder_source.sv
// rtl/retry_inorder_source.sv - issuing side of the in-order retry pair
//
// Tags each upstream operation with a rolling ID, keeps a copy of its payload
// in an ID-indexed replay buffer, and issues it into the protected datapath.
// Elements handed back by the far end are replayed from the buffer under fresh
// IDs. Replays always win over new upstream traffic, so results stay in order.
//
// Ports:
//   clk_i              clock, rising edge
//   rst_i              synchronous active-high reset
//   data_i/valid_i     upstream payload/valid
//   ready_o            upstream ready
//   data_o/valid_o     payload/valid into the datapath
//   id_o               ID travelling with data_o on the same handshake
//   ready_i            datapath ready
//   retry_valid        far end is returning an element for replay
//   retry_id           ID of the returned element
//   retry_ready        replay accepted this cycle
//   retry_lock         far end is in retry mode; new intake is blocked
//   retry_id_feedback  ID of the most recently issued element
module retry_inorder_source #(
  parameter type         DataType = logic,
  parameter int unsigned IDSize   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  DataType           data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output DataType           data_o,
  output logic [IDSize-1:0] id_o,
  output logic              valid_o,
  input  logic              ready_i,
  input  logic              retry_valid,
  input  logic [IDSize-1:0] retry_id,
  output logic              retry_ready,
  input  logic              retry_lock,
  output logic [IDSize-1:0] retry_id_feedback
);

  localparam int unsigned       Depth = 2 ** IDSize;
  localparam logic [IDSize-1:0] IdOne = IDSize'(1);

  logic [IDSize-1:0] id_q;
  DataType           mem [Depth];
  logic              issue;

  // Source select. A pending return takes the datapath regardless of lock;
  // otherwise lock parks upstream without dropping it (ready_o stays low).
  always_comb begin
    data_o      = data_i;
    valid_o     = 1'b0;
    ready_o     = 1'b0;
    retry_ready = 1'b0;
    if (retry_valid) begin
      data_o      = mem[retry_id];
      valid_o     = 1'b1;
      retry_ready = ready_i;
    end else if (!retry_lock) begin
      data_o  = data_i;
      valid_o = valid_i;
      ready_o = ready_i;
    end
  end

  assign issue             = valid_o & ready_i;
  assign id_o              = id_q;
  // Last issued ID; the far end latches it when it detects a failure.
  assign retry_id_feedback = id_q - IdOne;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_q <= '0;
    end else if (issue) begin
      id_q <= id_q + IdOne;
    end
  end

  // Every issued element, including replays, is stored under the ID it
  // leaves with, so a replayed element can fail and be replayed again.
  always_ff @(posedge clk_i) begin
    if (issue) begin
      mem[id_q] <= data_o;
    end
  end

endmodule

// File: tb/tb_retry_inorder_source.sv
// tb/tb_retry_inorder_source.sv - directed self-checking bench for retry_inorder_source
module tb_retry_inorder_source;

  typedef logic [7:0] data_t;

  logic       clk = 1'b0;
  logic       rst_i;
  data_t      data_i;
  logic       valid_i;
  logic       ready_o;
  data_t      data_o;
  logic [1:0] id_o;
  logic       valid_o;
  logic       ready_i;
  logic       retry_valid;
  logic [1:0] retry_id;
  logic       retry_ready;
  logic       retry_lock;
  logic [1:0] retry_id_feedback;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  retry_inorder_source #(
    .DataType(data_t),
    .IDSize  (2)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .data_i           (data_i),
    .valid_i          (valid_i),
    .ready_o          (ready_o),
    .data_o           (data_o),
    .id_o             (id_o),
    .valid_o          (valid_o),
    .ready_i          (ready_i),
    .retry_valid      (retry_valid),
    .retry_id         (retry_id),
    .retry_ready      (retry_ready),
    .retry_lock       (retry_lock),
    .retry_id_feedback(retry_id_feedback)
  );

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = 1'b0; data_i = '0; ready_i = 1'b1;
    retry_valid = 1'b0; retry_id = '0; retry_lock = 1'b0;
    tick(); tick();
    #1;
    if (id_o !== 2'd0) begin $display("FAIL reset_id got %0d exp 0", id_o); fails++; end
    tests++;
    if (retry_id_feedback !== 2'd3) begin $display("FAIL reset_fb got %0d exp 3", retry_id_feedback); fails++; end
    tests++;
    if (valid_o !== 1'b0) begin $display("FAIL reset_valid_o got %b exp 0", valid_o); fails++; end
    tests++;
    if (retry_ready !== 1'b0) begin $display("FAIL reset_retry_ready got %b exp 0", retry_ready); fails++; end
    tests++;
    if (ready_o !== 1'b1) begin $display("FAIL reset_ready_o_hi got %b exp 1", ready_o); fails++; end
    tests++;
    ready_i = 1'b0;
    #1;
    if (ready_o !== 1'b0) begin $display("FAIL reset_ready_o_lo got %b exp 0", ready_o); fails++; end
    tests++;
    ready_i = 1'b1;
    rst_i = 1'b0;
    tick();
    if (id_o !== 2'd0) begin $display("FAIL reset_release_id got %0d exp 0", id_o); fails++; end
    tests++;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      data_i = data_t'(8'h10 + i); valid_i = 1'b1; ready_i = 1'b1;
      #1;
      if (id_o !== 2'(i)) begin $display("FAIL basic_id[%0d] got %0d exp %0d", i, id_o, i); fails++; end
      tests++;
      if (valid_o !== 1'b1 || ready_o !== 1'b1) begin
        $display("FAIL basic_hs[%0d] got valid_o=%b ready_o=%b exp 1 1", i, valid_o, ready_o); fails++;
      end
      tests++;
      if (data_o !== data_t'(8'h10 + i)) begin
        $display("FAIL basic_data[%0d] got %h exp %h", i, data_o, 8'h10 + i); fails++;
      end
      tests++;
      tick();
    end
    valid_i = 1'b0;
    #1;
    if (id_o !== 2'd0) begin $display("FAIL basic_wrap got %0d exp 0", id_o); fails++; end
    tests++;
    if (retry_id_feedback !== 2'd3) begin $display("FAIL basic_fb got %0d exp 3", retry_id_feedback); fails++; end
    tests++;
  endtask

  // Starts with id_q=0. Ends with id_q=2, mem[1]=DD.
  task automatic test_replay();
    data_i = 8'hA0; valid_i = 1'b1; tick();
    data_i = 8'hB1; tick();
    data_i = 8'hC2; tick();
    // D waits upstream while the far end locks.
    data_i = 8'hDD; retry_lock = 1'b1;
    #1;
    if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
      $display("FAIL replay_hold got valid_o=%b ready_o=%b exp 0 0", valid_o, ready_o); fails++;
    end
    tests++;
    tick();
    retry_valid = 1'b1; retry_id = 2'd1;
    #1;
    if (data_o !== 8'hB1 || id_o !== 2'd3) begin
      $display("FAIL replay_b got data=%h id=%0d exp b1 3", data_o, id_o); fails++;
    end
    tests++;
    if (valid_o !== 1'b1 || retry_ready !== 1'b1 || ready_o !== 1'b0) begin
      $display("FAIL replay_b_hs got v=%b rr=%b ro=%b exp 1 1 0", valid_o, retry_ready, ready_o); fails++;
    end
    tests++;
    tick();
    retry_id = 2'd2;
    #1;
    if (data_o !== 8'hC2 || id_o !== 2'd0 || ready_o !== 1'b0) begin
      $display("FAIL replay_c got data=%h id=%0d ro=%b exp c2 0 0", data_o, id_o, ready_o); fails++;
    end
    tests++;
    tick();
    retry_valid = 1'b0;
    #1;
    if (valid_o !== 1'b0 || ready_o !== 1'b0) begin
      $display("FAIL replay_locked_idle got v=%b ro=%b exp 0 0", valid_o, ready_o); fails++;
    end
    tests++;
    tick();
    retry_lock = 1'b0;
    #1;
    if (data_o !== 8'hDD || id_o !== 2'd1 || valid_o !== 1'b1 || ready_o !== 1'b1) begin
      $display("FAIL replay_new_d got data=%h id=%0d v=%b ro=%b exp dd 1 1 1", data_o, id_o, valid_o, ready_o); fails++;
    end
    tests++;
    tick();
    valid_i = 1'b0;
    #1;
    if (retry_id_feedback !== 2'd1) begin $display("FAIL replay_fb got %0d exp 1", retry_id_feedback); fails++; end
    tests++;
  endtask

  // Starts with id_q=2, mem[1]=DD. Ends with id_q=3.
  task automatic test_backpressure();
    retry_lock = 1'b1; retry_valid = 1'b1; retry_id = 2'd1; ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (valid_o !== 1'b1 || retry_ready !== 1'b0 || id_o !== 2'd2) begin
        $display("FAIL bp_stall[%0d] got v=%b rr=%b id=%0d exp 1 0 2", i, valid_o, retry_ready, id_o); fails++;
      end
      tests++;
      tick();
    end
    ready_i = 1'b1;
    #1;
    if (retry_ready !== 1'b1 || data_o !== 8'hDD) begin
      $display("FAIL bp_go got rr=%b data=%h exp 1 dd", retry_ready, data_o); fails++;
    end
    tests++;
    tick();
    retry_valid = 1'b0; retry_lock = 1'b0;
    #1;
    if (id_o !== 2'd3) begin $display("FAIL bp_advance got %0d exp 3", id_o); fails++; end
    tests++;
  endtask

  // Starts with id_q=3. Ends with id_q=0.
  task automatic test_lock_hold();
    retry_lock = 1'b1; valid_i = 1'b1; data_i = 8'h55; ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (valid_o !== 1'b0 || ready_o !== 1'b0 || id_o !== 2'd3) begin
        $display("FAIL lock_hold[%0d] got v=%b ro=%b id=%0d exp 0 0 3", i, valid_o, ready_o, id_o); fails++;
      end
      tests++;
      tick();
    end
    retry_lock = 1'b0;
    #1;
    if (valid_o !== 1'b1 || data_o !== 8'h55 || id_o !== 2'd3) begin
      $display("FAIL lock_resume got v=%b data=%h id=%0d exp 1 55 3", valid_o, data_o, id_o); fails++;
    end
    tests++;
    tick();
    valid_i = 1'b0;
    #1;
    if (id_o !== 2'd0) begin $display("FAIL lock_after got %0d exp 0", id_o); fails++; end
    tests++;
  endtask

  task automatic test_reset_mid();
    valid_i = 1'b1; ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      data_i = data_t'(8'h60 + i);
      tick();
    end
    valid_i = 1'b0;
    #1;
    if (id_o !== 2'd1) begin $display("FAIL mid_pre got %0d exp 1", id_o); fails++; end
    tests++;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    if (id_o !== 2'd0 || retry_id_feedback !== 2'd3) begin
      $display("FAIL mid_reset got id=%0d fb=%0d exp 0 3", id_o, retry_id_feedback); fails++;
    end
    tests++;
    valid_i = 1'b1; data_i = 8'h77;
    #1;
    if (id_o !== 2'd0 || valid_o !== 1'b1 || data_o !== 8'h77) begin
      $display("FAIL mid_first got id=%0d v=%b data=%h exp 0 1 77", id_o, valid_o, data_o); fails++;
    end
    tests++;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic test_repeated();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    valid_i = 1'b1; ready_i = 1'b1;
    data_i = 8'hE0; tick();
    data_i = 8'hF1; tick();
    data_i = 8'h92; tick();
    valid_i = 1'b0; retry_lock = 1'b1;
    retry_valid = 1'b1; retry_id = 2'd0;
    #1;
    if (data_o !== 8'hE0 || id_o !== 2'd3) begin
      $display("FAIL rep_first got data=%h id=%0d exp e0 3", data_o, id_o); fails++;
    end
    tests++;
    tick();
    retry_id = 2'd3;
    #1;
    if (data_o !== 8'hE0 || id_o !== 2'd0 || retry_ready !== 1'b1) begin
      $display("FAIL rep_second got data=%h id=%0d rr=%b exp e0 0 1", data_o, id_o, retry_ready); fails++;
    end
    tests++;
    tick();
    retry_valid = 1'b0; retry_lock = 1'b0;
    #1;
    if (id_o !== 2'd1 || retry_id_feedback !== 2'd0) begin
      $display("FAIL rep_after got id=%0d fb=%0d exp 1 0", id_o, retry_id_feedback); fails++;
    end
    tests++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_replay();
    test_backpressure();
    test_lock_hold();
    test_reset_mid();
    test_repeated();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
